// File: rtl/ram_io_responder_pkg.sv
// rtl/ram_io_responder_pkg.sv - shared constants and types for the RAM/IO responder
//
// Purpose: address-map constants for the IO window, RAM sizing, and the read
// source select used by the registered read path.
package ram_io_responder_pkg;

  localparam int unsigned RAM_ADDR_W_DEF = 17;
  localparam int unsigned RAM_SIZE       = 1 << RAM_ADDR_W_DEF;

  localparam logic [31:0] IO_BASE        = 32'h0003_0000;
  // Bits [17:16] == 2'b11 select the IO window; every other address is RAM.
  localparam logic [31:0] IO_DECODE_MASK = 32'h0003_0000;
  localparam logic [15:0] IO_TX_RX_OFS   = 16'h0000;
  localparam logic [15:0] IO_CTRL_OFS    = 16'h0004;

  // Which registered source drives mem_din in the cycle after an access.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_IO   = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/ram_io_responder_io_tx_fifo.sv
// rtl/ram_io_responder_io_tx_fifo.sv - synchronous TX byte FIFO with occupancy count
//
// Purpose: power-of-two deep byte FIFO. Pushes to a full FIFO and pops from an
// empty FIFO are ignored. full_margin_o is registered and is 1 when the
// occupancy after this edge is within two slots of full.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   push_i, data_i  write request and byte
//   pop_i           remove head
//   data_o          head byte (combinational)
//   count_o         current occupancy
//   empty_o, full_o occupancy flags
//   full_margin_o   registered (next count >= DEPTH-2)
module io_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       full_margin_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [0:DEPTH-1];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          margin_q, margin_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d   = wptr_q + AW'(push_ok);
    rptr_d   = rptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    margin_d = (count_d >= CW'(DEPTH - 2));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      margin_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      margin_q <= margin_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= data_i;
  end

  assign data_o        = mem[rptr_q];
  assign count_o       = count_q;
  assign full_margin_o = margin_q;

endmodule

// File: rtl/ram_io_responder.sv
// rtl/ram_io_responder.sv - byte RAM plus memory-mapped TX/RX/halt IO window
//
// Purpose: responder for the controller's byte bus. Non-IO addresses hit a
// synchronous byte RAM; the IO window holds a TX FIFO, an RX holding register
// and a sticky halt flag. mem_din is registered (one cycle after address).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   mem_a, mem_dout, mem_wr          address, write data, write strobe
//   mem_din                          read data, one cycle after mem_a
//   io_buffer_full                   TX back-pressure to the controller
//   tx_data, tx_valid, tx_ready      TX FIFO drain port
//   rx_data, rx_valid, rx_ready      RX holding register fill port
//   tx_overflow, halt                sticky status flags
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter logic [31:0] IO_BASE    = ram_io_responder_pkg::IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        halt
);

  logic [7:0] ram [0:(1 << RAM_ADDR_W)-1];
  logic [7:0] ram_rd_q;

  logic        is_io, io_txrx, io_ctrl;
  logic [15:0] io_ofs;

  logic       fifo_empty, fifo_full, fifo_margin;
  logic [7:0] fifo_head;
  logic [$clog2(TX_DEPTH):0] fifo_count;
  logic       tx_push_req, tx_pop;

  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_capture, rx_pop;

  logic       tx_overflow_q, tx_overflow_d;
  logic       halt_q, halt_d;

  rd_sel_e    rd_sel_q, rd_sel_d;
  logic [7:0] io_rd_q, io_rd_d;

  assign is_io   = ((mem_a & IO_DECODE_MASK) == (IO_BASE & IO_DECODE_MASK));
  assign io_ofs  = mem_a[15:0];
  assign io_txrx = is_io && (io_ofs == IO_TX_RX_OFS);
  assign io_ctrl = is_io && (io_ofs == IO_CTRL_OFS);

  assign tx_push_req = mem_wr & io_txrx;
  assign tx_pop      = ~fifo_empty & tx_ready;

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (tx_push_req),
    .data_i        (mem_dout),
    .pop_i         (tx_pop),
    .data_o        (fifo_head),
    .count_o       (fifo_count),
    .empty_o       (fifo_empty),
    .full_o        (fifo_full),
    .full_margin_o (fifo_margin)
  );

  // A capture only happens into an empty register, so when it coincides with
  // a read the read sees the old (empty -> 0) contents and the new byte stays.
  assign rx_capture = rx_valid & ~rx_full_q;
  assign rx_pop     = ~mem_wr & io_txrx;

  always_comb begin
    rx_full_d     = rx_capture | (rx_full_q & ~rx_pop);
    rx_byte_d     = rx_capture ? rx_data : rx_byte_q;
    tx_overflow_d = tx_overflow_q | (tx_push_req & fifo_full);
    halt_d        = halt_q | (mem_wr & io_ctrl);

    rd_sel_d = RD_ZERO;
    if (!mem_wr) rd_sel_d = is_io ? RD_IO : RD_RAM;

    io_rd_d = 8'h00;
    if (io_txrx)      io_rd_d = rx_full_q ? rx_byte_q : 8'h00;
    else if (io_ctrl) io_rd_d = {6'b0, rx_full_q, ~fifo_empty};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full_q     <= 1'b0;
      rx_byte_q     <= 8'h00;
      tx_overflow_q <= 1'b0;
      halt_q        <= 1'b0;
      rd_sel_q      <= RD_ZERO;
      io_rd_q       <= 8'h00;
    end else begin
      rx_full_q     <= rx_full_d;
      rx_byte_q     <= rx_byte_d;
      tx_overflow_q <= tx_overflow_d;
      halt_q        <= halt_d;
      rd_sel_q      <= rd_sel_d;
      io_rd_q       <= io_rd_d;
    end
  end

  // RAM contents survive reset. The read on a write cycle returns the old
  // byte, but rd_sel masks it to 0, so no forwarding is needed.
  always_ff @(posedge clk) begin
    if (mem_wr && !is_io) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    ram_rd_q <= ram[mem_a[RAM_ADDR_W-1:0]];
  end

  always_comb begin
    mem_din = 8'h00;
    case (rd_sel_q)
      RD_RAM:  mem_din = ram_rd_q;
      RD_IO:   mem_din = io_rd_q;
      default: mem_din = 8'h00;
    endcase
  end

  assign io_buffer_full = fifo_margin;
  assign tx_valid       = ~fifo_empty;
  // Gated so the output is 0 while empty (including during reset).
  assign tx_data        = fifo_empty ? 8'h00 : fifo_head;
  // Held low during reset so every output reads 0 while rst is asserted.
  assign rx_ready       = ~rx_full_q & ~rst;
  assign tx_overflow    = tx_overflow_q;
  assign halt           = halt_q;

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-wide memory bus driven by the memory controller: it takes mem_a, mem_dout and mem_wr, and returns mem_din and io_buffer_full.
- Contains a synchronous byte RAM and a memory-mapped IO window.
- The IO window provides a TX byte FIFO drained through a valid/ready port, a single-byte RX holding register, and a halt flag.
- Sits between the CPU top and the board/testbench UART model.

Parameters:
- RAM_ADDR_W, 17, byte-address width of the RAM (2^17 bytes).
- TX_DEPTH, 8, TX FIFO depth in bytes (power of two, >= 4).
- IO_BASE, 32'h0003_0000, base address of the IO window. Any mem_a with mem_a[17:16] == 2'b11 is IO.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mem_a  in  32  byte address from the controller.
- mem_dout  in  8  write data from the controller.
- mem_wr  in  1  1 = write, 0 = read (a read is performed every cycle).
- mem_din  out  8  read data; valid one cycle after its address.
- io_buffer_full  out  1  back-pressure to the controller; the controller must not issue writes while it is 1.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data on this edge.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data present; captured only if the holding register is empty.
- rx_ready  out  1  holding register empty.
- tx_overflow  out  1  sticky; an IO write was dropped because the FIFO was full.
- halt  out  1  sticky; set by a write to IO_BASE+4.

Behaviour:
- Reset (async, rst=1): all outputs 0. TX FIFO pointers and count cleared. RX holding register cleared and marked empty. RAM contents are not reset.
- Address decode is done on mem_a each cycle:
  - mem_a[17:16] != 2'b11: RAM, indexed by mem_a[RAM_ADDR_W-1:0].
  - IO_BASE+0: TX data on write, RX data on read.
  - IO_BASE+4: halt on write; a read returns {6'b0, rx_full, tx_nonempty}.
  - Any other IO offset: a write is ignored and a read returns 0.
- RAM write: on the clk edge with mem_wr=1, ram[a] <= mem_dout. There is no read-during-write forwarding; the next-cycle mem_din for a write cycle is 0.
- Read: mem_din is registered. The value for the address presented in cycle N appears in cycle N+1. mem_din is 0 for any cycle after a write.
- RX read (IO_BASE+0, mem_wr=0):
  - The cycle-N+1 mem_din is the held byte if the register is full, otherwise 0.
  - The register is emptied at the edge of cycle N.
  - An RX capture and a pop in the same cycle: the pop returns the old byte and the new byte is stored.
- TX write (IO_BASE+0, mem_wr=1):
  - The byte is pushed if count < TX_DEPTH.
  - Otherwise it is dropped and tx_overflow is set.
- TX drain: when tx_valid && tx_ready, the head is popped. A push and a pop in the same cycle leave count unchanged; both pointers advance and wrap modulo TX_DEPTH.
- io_buffer_full is registered and equals (next_count >= TX_DEPTH-2). The two-slot margin covers the controller's one-cycle combinational use of the flag.
- tx_data is valid whenever tx_valid=1 and is combinational from the FIFO head.
- halt: set by a write to IO_BASE+4; cleared only by rst.
- Reset mid-transfer: all in-flight state is discarded immediately; the next cycle after rst falls behaves as fresh.

Decomposition:
- Shared package constants: IO_BASE, IO_TX_RX_OFS = 0, IO_CTRL_OFS = 4, the IO decode mask, and RAM_SIZE.
- One sub-module, io_tx_fifo: parameterised sync FIFO with count, push, pop, full_margin output.
- RAM and decode stay in the top module.

Test Plan:
- Write 8'hA5 to 0x00010, then read 0x00010 the next cycle -> mem_din = 8'hA5 one cycle after the read address; a read of 0x00011 -> its preloaded value.
- Four back-to-back byte writes 0x11,0x22,0x33,0x44 to 0x100..0x103, then a 4-cycle read sequence -> mem_din streams 0x11,0x22,0x33,0x44 with one-cycle lag.
- tx_ready=0, six writes to 0x30000 -> io_buffer_full rises after the 6th push (count=6, TX_DEPTH=8); tx_valid=1, tx_data = first byte.
- tx_ready=0, nine writes to 0x30000 -> 8 bytes stored, tx_overflow=1. Then raise tx_ready -> bytes drain in order, tx_valid falls after 8 pops, and io_buffer_full drops when count reaches 5.
- rx_valid pulse with 8'h5A, then read 0x30000 -> mem_din = 8'h5A and rx_ready returns to 1. A second read -> mem_din = 0.
- Write to 0x30004 -> halt=1. Assert rst mid-sequence -> all outputs 0 asynchronously and halt cleared.
